// File: rtl/efuse_seq_ctrl.sv
// eFuse program/read sequencer: power-switch ramp, per-bit SCLK/PGM strobes, serial read-back.
// Optional EFUSE_VERIFY_EN chains a read after programming and flags read-back mismatches.
module efuse_seq_ctrl #(
   parameter int FUSE_BITS = 32,
   parameter int PWR_CYC   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic [3:0]           tckhp,
   input  logic [FUSE_BITS-1:0] prog,
   input  logic                 dout,
   output logic                 en,
   output logic                 rampena,
   output logic                 short,
   output logic                 csb,
   output logic                 pgm,
   output logic                 sclk,
   output logic                 busy,
   output logic                 done,
   output logic [FUSE_BITS-1:0] rd_data,
   output logic                 verify_err
);

   localparam int BW   = (FUSE_BITS > 1) ? $clog2(FUSE_BITS) : 1;
   localparam int TMAX = (PWR_CYC > 15) ? PWR_CYC : 15;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [BW-1:0] LAST   = BW'(FUSE_BITS - 1);
   localparam logic [TW-1:0] PWR_LD = TW'(PWR_CYC - 1);

   typedef enum logic [3:0] {
      IDLE, PWR_UP, RAMP, CS_SETUP, BIT_HI, BIT_LO, PWR_DN, RD_SETUP, RD_HI, RD_LO
   } state_e;

   state_e               state_q, state_d;
   logic                 start_q;
   logic [BW-1:0]        bit_q, bit_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [FUSE_BITS-1:0] prog_q, prog_d;
   logic [3:0]           t_q, t_d;
   logic [FUSE_BITS-1:0] rd_data_q, rd_data_d;
   logic en_q, en_d, rampena_q, rampena_d, short_q, short_d, csb_q, csb_d;
   logic pgm_q, pgm_d, sclk_q, sclk_d, busy_q, busy_d, done_q, done_d;
   logic accept;
`ifdef EFUSE_VERIFY_EN
   logic ver_q, ver_d, verify_err_q, verify_err_d;
`endif

   always_comb begin
      state_d   = state_q;
      bit_d     = bit_q;
      timer_d   = timer_q;
      prog_d    = prog_q;
      t_d       = t_q;
      rd_data_d = rd_data_q;
`ifdef EFUSE_VERIFY_EN
      ver_d        = ver_q;
      verify_err_d = verify_err_q;
`endif
      accept = start & ~start_q & ~busy_q & ((mode == 2'b01) | (mode == 2'b10));
      case (state_q)
         IDLE: if (accept) begin
            prog_d  = prog;
            t_d     = (tckhp == 4'd0) ? 4'd1 : tckhp;
            bit_d   = '0;
            timer_d = PWR_LD;
            state_d = (mode == 2'b01) ? PWR_UP : RD_SETUP;
`ifdef EFUSE_VERIFY_EN
            ver_d   = (mode == 2'b01);
`endif
         end
         PWR_UP: if (timer_q == '0) begin
            state_d = RAMP;
            timer_d = PWR_LD;
         end else timer_d = timer_q - 1'b1;
         RAMP: if (timer_q == '0) state_d = CS_SETUP;
               else timer_d = timer_q - 1'b1;
         CS_SETUP: begin
            state_d = BIT_HI;
            timer_d = TW'(t_q) - 1'b1;
         end
         BIT_HI: if (timer_q == '0) state_d = BIT_LO;
                 else timer_d = timer_q - 1'b1;
         BIT_LO: if (bit_q == LAST) begin
            state_d = PWR_DN;
            timer_d = PWR_LD;
         end else begin
            bit_d   = bit_q + 1'b1;
            timer_d = TW'(t_q) - 1'b1;
            state_d = BIT_HI;
         end
         PWR_DN: if (timer_q == '0) begin
`ifdef EFUSE_VERIFY_EN
            state_d = RD_SETUP;
            bit_d   = '0;
`else
            state_d = IDLE;
`endif
         end else timer_d = timer_q - 1'b1;
         RD_SETUP: state_d = RD_HI;
         RD_HI: begin
            rd_data_d[bit_q] = dout;
            state_d = RD_LO;
         end
         RD_LO: if (bit_q == LAST) begin
            state_d = IDLE;
`ifdef EFUSE_VERIFY_EN
            // last bit landed on RD_HI->RD_LO, so rd_data_q is complete here
            if (ver_q) verify_err_d = (rd_data_q != prog_q);
`endif
         end else begin
            bit_d   = bit_q + 1'b1;
            state_d = RD_HI;
         end
         default: state_d = IDLE;
      endcase

      // Outputs decode the next state so every pin comes straight from a flop.
      en_d      = (state_d == PWR_UP) | (state_d == RAMP) | (state_d == CS_SETUP) |
                  (state_d == BIT_HI) | (state_d == BIT_LO) | (state_d == PWR_DN);
      short_d   = ~en_d;
      rampena_d = (state_d == RAMP) | (state_d == CS_SETUP) |
                  (state_d == BIT_HI) | (state_d == BIT_LO);
      csb_d     = ~((state_d == CS_SETUP) | (state_d == BIT_HI) | (state_d == BIT_LO) |
                    (state_d == RD_SETUP) | (state_d == RD_HI)  | (state_d == RD_LO));
      sclk_d    = (state_d == BIT_HI) | (state_d == RD_HI);
      pgm_d     = (state_d == BIT_HI) & prog_q[bit_d];
      busy_d    = (state_d != IDLE);
      done_d    = (state_q != IDLE) & (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         start_q   <= 1'b0;
         bit_q     <= '0;
         timer_q   <= '0;
         prog_q    <= '0;
         t_q       <= 4'd1;
         rd_data_q <= '0;
         en_q      <= 1'b0;
         rampena_q <= 1'b0;
         short_q   <= 1'b1;
         csb_q     <= 1'b1;
         pgm_q     <= 1'b0;
         sclk_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef EFUSE_VERIFY_EN
         ver_q        <= 1'b0;
         verify_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         start_q   <= start;
         bit_q     <= bit_d;
         timer_q   <= timer_d;
         prog_q    <= prog_d;
         t_q       <= t_d;
         rd_data_q <= rd_data_d;
         en_q      <= en_d;
         rampena_q <= rampena_d;
         short_q   <= short_d;
         csb_q     <= csb_d;
         pgm_q     <= pgm_d;
         sclk_q    <= sclk_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef EFUSE_VERIFY_EN
         ver_q        <= ver_d;
         verify_err_q <= verify_err_d;
`endif
      end
   end

   assign en      = en_q;
   assign rampena = rampena_q;
   assign short   = short_q;
   assign csb     = csb_q;
   assign pgm     = pgm_q;
   assign sclk    = sclk_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign rd_data = rd_data_q;
`ifdef EFUSE_VERIFY_EN
   assign verify_err = verify_err_q;
`else
   assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Directed bench for efuse_seq_ctrl with FUSE_BITS=8, PWR_CYC=4; per-scenario tasks with inline checks.
module tb_efuse_seq_ctrl;

   localparam int N = 8;
   localparam int P = 4;
`ifdef EFUSE_VERIFY_EN
   localparam int RD_EXTRA = 1 + 2 * N;
`else
   localparam int RD_EXTRA = 0;
`endif

   logic clk = 1'b0;
   logic rst, start, dout;
   logic [1:0] mode;
   logic [3:0] tckhp;
   logic [N-1:0] prog;
   logic en, rampena, short, csb, pgm, sclk, busy, done, verify_err;
   logic [N-1:0] rd_data;

   int checks = 0;
   int errors = 0;

   int busy_cnt, pulses_p, pulses_r, hi_min, hi_max, run, pgm_bad, pgm_cnt, en_cnt, done_mid, rd_idx;
   logic done_end, done_after, busy_after, en_end, ver_end, prev_sclk;
   logic [N-1:0] rd_end, exp_prog, rd_pat;

   efuse_seq_ctrl #(.FUSE_BITS(N), .PWR_CYC(P)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .tckhp(tckhp), .prog(prog),
      .dout(dout), .en(en), .rampena(rampena), .short(short), .csb(csb), .pgm(pgm),
      .sclk(sclk), .busy(busy), .done(done), .rd_data(rd_data), .verify_err(verify_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] m, input logic [3:0] t, input logic [N-1:0] p);
      mode = m; tckhp = t; prog = p; start = 1'b1;
   endtask

   // Runs one operation to its done cycle, gathering strobe statistics and serving dout.
   task automatic run_op(input int restart_at);
      int w;
      w = 0; busy_cnt = 0; pulses_p = 0; pulses_r = 0; hi_min = 99; hi_max = 0; run = 0;
      pgm_bad = 0; pgm_cnt = 0; en_cnt = 0; done_mid = 0; rd_idx = 0; prev_sclk = 1'b0; dout = 1'b0;
      tick();
      while (busy !== 1'b1 && w < 4) begin tick(); w++; end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL op_start busy=%b want 1", busy); end
      start = 1'b0;
      while (busy === 1'b1 && busy_cnt < 300) begin
         busy_cnt++;
         if (restart_at > 0 && busy_cnt == restart_at) begin
            start = 1'b1; mode = 2'b10; prog = ~prog; tckhp = 4'd1;
         end
         if (restart_at > 0 && busy_cnt == restart_at + 3) start = 1'b0;
         if (done) done_mid++;
         if (en) en_cnt++;
         if (pgm) pgm_cnt++;
         if (pgm && !sclk) pgm_bad++;
         if (sclk && !prev_sclk) begin
            if (en) pulses_p++; else pulses_r++;
            run = 0;
         end
         if (sclk) run++;
         if (!sclk && prev_sclk && en) begin
            if (run < hi_min) hi_min = run;
            if (run > hi_max) hi_max = run;
         end
         if (sclk && en && pulses_p >= 1 && pulses_p <= N && pgm !== exp_prog[pulses_p-1]) pgm_bad++;
         if (sclk && !en && !csb) begin
            if (rd_idx < N) dout = rd_pat[rd_idx];
            rd_idx++;
         end
         prev_sclk = sclk;
         tick();
      end
      checks++;
      if (busy === 1'b1) begin errors++; $display("FAIL op_timeout busy still high after %0d", busy_cnt); end
      done_end = done; en_end = en; rd_end = rd_data; ver_end = verify_err;
      tick();
      done_after = done; busy_after = busy;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; mode = 2'b00; tckhp = 4'd0; prog = '0; dout = 1'b0;
      tick(); tick(); tick();
      checks++; if (en !== 1'b0)      begin errors++; $display("FAIL rst_en got %b want 0", en); end
      checks++; if (rampena !== 1'b0) begin errors++; $display("FAIL rst_rampena got %b want 0", rampena); end
      checks++; if (short !== 1'b1)   begin errors++; $display("FAIL rst_short got %b want 1", short); end
      checks++; if (csb !== 1'b1)     begin errors++; $display("FAIL rst_csb got %b want 1", csb); end
      checks++; if (pgm !== 1'b0 || sclk !== 1'b0) begin errors++; $display("FAIL rst_strobes pgm=%b sclk=%b want 0 0", pgm, sclk); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_hs busy=%b done=%b want 0 0", busy, done); end
      checks++; if (rd_data !== 8'h00 || verify_err !== 1'b0) begin errors++; $display("FAIL rst_data rd=%h ve=%b want 00 0", rd_data, verify_err); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_program();
      exp_prog = 8'hA5; rd_pat = 8'hA5;
      launch(2'b01, 4'd3, 8'hA5);
      run_op(0);
      checks++; if (busy_cnt != 45 + RD_EXTRA) begin errors++; $display("FAIL prog_busy got %0d want %0d", busy_cnt, 45 + RD_EXTRA); end
      checks++; if (pulses_p != 8) begin errors++; $display("FAIL prog_pulses got %0d want 8", pulses_p); end
      checks++; if (hi_min != 3 || hi_max != 3) begin errors++; $display("FAIL prog_hi min=%0d max=%0d want 3 3", hi_min, hi_max); end
      checks++; if (pgm_bad != 0) begin errors++; $display("FAIL prog_pgm_pattern bad=%0d want 0", pgm_bad); end
      checks++; if (pgm_cnt != 12) begin errors++; $display("FAIL prog_pgm_cycles got %0d want 12", pgm_cnt); end
      checks++; if (en_cnt != 45) begin errors++; $display("FAIL prog_en_cycles got %0d want 45", en_cnt); end
      checks++; if (done_end !== 1'b1 || done_mid != 0) begin errors++; $display("FAIL prog_done end=%b mid=%0d want 1 0", done_end, done_mid); end
      checks++; if (done_after !== 1'b0 || en_end !== 1'b0) begin errors++; $display("FAIL prog_after done=%b en=%b want 0 0", done_after, en_end); end
`ifdef EFUSE_VERIFY_EN
      checks++; if (rd_end !== 8'hA5 || pulses_r != 8) begin errors++; $display("FAIL prog_readback rd=%h pulses=%0d want a5 8", rd_end, pulses_r); end
`else
      checks++; if (rd_end !== 8'h00 || pulses_r != 0) begin errors++; $display("FAIL prog_readback rd=%h pulses=%0d want 00 0", rd_end, pulses_r); end
`endif
      checks++; if (ver_end !== 1'b0) begin errors++; $display("FAIL prog_verify got %b want 0", ver_end); end
   endtask

   task automatic test_tckhp_zero();
      exp_prog = 8'h5A; rd_pat = 8'h5A;
      launch(2'b01, 4'd0, 8'h5A);
      run_op(0);
      checks++; if (busy_cnt != 29 + RD_EXTRA) begin errors++; $display("FAIL t0_busy got %0d want %0d", busy_cnt, 29 + RD_EXTRA); end
      checks++; if (hi_min != 1 || hi_max != 1 || pulses_p != 8) begin errors++; $display("FAIL t0_hi min=%0d max=%0d n=%0d want 1 1 8", hi_min, hi_max, pulses_p); end
      checks++; if (pgm_bad != 0 || pgm_cnt != 4) begin errors++; $display("FAIL t0_pgm bad=%0d cyc=%0d want 0 4", pgm_bad, pgm_cnt); end
   endtask

   task automatic test_read();
      exp_prog = 8'h00; rd_pat = 8'h3C;
      launch(2'b10, 4'd5, 8'hFF);
      run_op(0);
      checks++; if (busy_cnt != 17) begin errors++; $display("FAIL rd_busy got %0d want 17", busy_cnt); end
      checks++; if (rd_end !== 8'h3C) begin errors++; $display("FAIL rd_data got %h want 3c", rd_end); end
      checks++; if (en_cnt != 0 || pgm_cnt != 0) begin errors++; $display("FAIL rd_power en=%0d pgm=%0d want 0 0", en_cnt, pgm_cnt); end
      checks++; if (pulses_r != 8 || pulses_p != 0) begin errors++; $display("FAIL rd_pulses r=%0d p=%0d want 8 0", pulses_r, pulses_p); end
      checks++; if (done_end !== 1'b1 || done_after !== 1'b0) begin errors++; $display("FAIL rd_done end=%b after=%b want 1 0", done_end, done_after); end
   endtask

   task automatic test_bad_mode();
      int act;
      act = 0;
      launch(2'b11, 4'd3, 8'hFF);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b0 || csb !== 1'b1) act++;
      end
      start = 1'b0; mode = 2'b00;
      tick();
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (busy !== 1'b0 || done !== 1'b0 || csb !== 1'b1) act++;
      end
      start = 1'b0;
      tick();
      checks++; if (act != 0) begin errors++; $display("FAIL bad_mode activity cycles=%0d want 0", act); end
      checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL bad_mode rd=%h want 3c", rd_data); end
   endtask

   task automatic test_back_to_back();
      exp_prog = 8'hA5; rd_pat = 8'hA5;
      launch(2'b01, 4'd3, 8'hA5);
      run_op(20);
      checks++; if (busy_cnt != 45 + RD_EXTRA) begin errors++; $display("FAIL b2b_busy got %0d want %0d", busy_cnt, 45 + RD_EXTRA); end
      checks++; if (pgm_bad != 0 || pgm_cnt != 12) begin errors++; $display("FAIL b2b_pgm bad=%0d cyc=%0d want 0 12", pgm_bad, pgm_cnt); end
      checks++; if (done_mid != 0 || done_after !== 1'b0 || busy_after !== 1'b0) begin errors++; $display("FAIL b2b_extra mid=%0d done=%b busy=%b want 0 0 0", done_mid, done_after, busy_after); end
   endtask

`ifdef EFUSE_VERIFY_EN
   task automatic test_verify();
      exp_prog = 8'hA5; rd_pat = 8'hA4;
      launch(2'b01, 4'd3, 8'hA5);
      run_op(0);
      checks++; if (busy_cnt != 62) begin errors++; $display("FAIL ver_busy got %0d want 62", busy_cnt); end
      checks++; if (ver_end !== 1'b1 || rd_end !== 8'hA4) begin errors++; $display("FAIL ver_mismatch ve=%b rd=%h want 1 a4", ver_end, rd_end); end
      rd_pat = 8'hA5;
      launch(2'b01, 4'd3, 8'hA5);
      run_op(0);
      checks++; if (ver_end !== 1'b0 || rd_end !== 8'hA5) begin errors++; $display("FAIL ver_match ve=%b rd=%h want 0 a5", ver_end, rd_end); end
   endtask
`endif

   task automatic test_reset_mid();
      int w;
      w = 0;
      launch(2'b01, 4'd3, 8'hA5);
      tick();
      while (busy !== 1'b1 && w < 4) begin tick(); w++; end
      start = 1'b0;
      // busy cycle 11 sits inside the bit-0 SCLK high phase, where pgm=1
      for (int i = 0; i < 10; i++) tick();
      checks++; if (pgm !== 1'b1 || sclk !== 1'b1 || en !== 1'b1) begin errors++; $display("FAIL mid_pre pgm=%b sclk=%b en=%b want 1 1 1", pgm, sclk, en); end
      rst = 1'b0;
      tick();
      checks++; if (csb !== 1'b1 || pgm !== 1'b0 || sclk !== 1'b0) begin errors++; $display("FAIL mid_strobes csb=%b pgm=%b sclk=%b want 1 0 0", csb, pgm, sclk); end
      checks++; if (en !== 1'b0 || short !== 1'b1 || rampena !== 1'b0) begin errors++; $display("FAIL mid_power en=%b short=%b ramp=%b want 0 1 0", en, short, rampena); end
      checks++; if (busy !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL mid_state busy=%b rd=%h want 0 00", busy, rd_data); end
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (busy !== 1'b0 || done !== 1'b0 || csb !== 1'b1) begin errors++; $display("FAIL mid_release busy=%b done=%b csb=%b want 0 0 1", busy, done, csb); end
   endtask

   initial begin
      test_reset();
      test_program();
      test_tckhp_zero();
      test_read();
      test_bad_mode();
      test_back_to_back();
`ifdef EFUSE_VERIFY_EN
      test_verify();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/efuse_seq_ctrl.md
# efuse_seq_ctrl

Parametrised eFuse program/read sequencer; next generation of the fixed 32-bit eFuse controller. It sequences the power switch (EN/RAMPENA/SHORT) and the eFuse macro strobes (CSB/PGM/SCLK) for a FUSE_BITS-wide fuse array. It adds a serial read-back path with captured data and a busy/done handshake. It does its own start-edge detection in-clock, so there is no analog delay line. It sits after the clock divider and runs on the divided fuse clock.

## Interface
- FUSE_BITS, 32, number of fuse bits programmed/read, 2..256
- PWR_CYC, 8, clk cycles per power-switch step (EN settle, RAMPENA settle, power-down), ≥1
- clk  in  1  divided fuse clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  level; rising edge (sampled in clk) launches an operation
- mode  in  2  2'b01 program, 2'b10 read; other codes: start ignored
- tckhp  in  4  SCLK high period in program mode, cycles; 0 treated as 1
- prog  in  FUSE_BITS  program data, captured on accepted start
- dout  in  1  eFuse serial read data
- en, rampena, short  out  1 each  power-switch controls
- csb  out  1  eFuse chip select, active-low
- pgm  out  1  eFuse program strobe
- sclk  out  1  eFuse serial clock
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse at completion
- rd_data  out  FUSE_BITS  last read-back word
- verify_err  out  1  read-back mismatch flag (see Configuration)

## Operation
- All outputs are registered. Reset values: en=0, rampena=0, short=1, csb=1, pgm=0, sclk=0, busy=0, done=0, rd_data=0, verify_err=0. FSM=IDLE, start_q=0.
- Accept: start & ~start_q & ~busy & mode∈{01,10}. Latch prog, mode, and tckhp (max(tckhp,1) → T).
- Start edges while busy are dropped, not queued. Changing mode, prog or tckhp mid-operation has no effect.
- States: IDLE → (program) PWR_UP → RAMP → CS_SETUP → BIT_HI ⇄ BIT_LO → PWR_DN → IDLE. (read) RD_SETUP → RD_HI ⇄ RD_LO → IDLE.
- PWR_UP: en=1, short=0, PWR_CYC cycles.
- RAMP: adds rampena=1, PWR_CYC cycles.
- CS_SETUP: csb=0, 1 cycle.
- BIT_HI (bit i, LSB first): sclk=1 and pgm=prog[i] for T cycles.
- BIT_LO: sclk=0, pgm=0, 1 cycle. Increment i; after bit FUSE_BITS-1 go to PWR_DN.
- PWR_DN: csb=1, rampena=0, en=1, short=0, PWR_CYC cycles. Then en=0, short=1 on return to IDLE.
- Read mode keeps the power switch off: en=0, short=1.
- RD_SETUP: csb=0, pgm=0, 1 cycle.
- RD_HI: sclk=1, 1 cycle. RD_LO: sclk=0, 1 cycle; dout sampled into rd_data[i] on entry to RD_LO.
- After the last bit, csb=1. rd_data updates bitwise during the read and holds until the next read or reset.
- Counters: bit index $clog2(FUSE_BITS) bits; timer wide enough for max(PWR_CYC,15). No wrap: bit index stops at FUSE_BITS-1.
- Reset mid-operation: on the next clk edge all outputs take reset values, including csb=1, pgm=0 and en=0. The partial program is abandoned.

## Timing
- busy rises the cycle after the accepting clk edge and stays high until the cycle done pulses.
- done is high for exactly 1 cycle, on the first IDLE cycle; busy=0 in that same cycle. A new start may be accepted in the done cycle.
- Program duration (busy high): 3·PWR_CYC + 1 + FUSE_BITS·(T+1) cycles.
- Read duration: 1 + 2·FUSE_BITS cycles.
- pgm only changes while sclk=0 or at BIT_HI entry, together with sclk; no pgm pulse occurs outside BIT_HI.

## Configuration
- EFUSE_VERIFY_EN defined: after PWR_DN, program mode chains into RD_SETUP with no IDLE cycle. It performs a full read, then compares rd_data with the latched prog.
  - verify_err is set on mismatch and cleared on match, updated in the done cycle.
  - Program duration grows by 1 + 2·FUSE_BITS cycles.
- EFUSE_VERIFY_EN undefined: no chained read. verify_err is tied 0. Comparator and chaining logic are absent.

## Test plan
- Reset: hold rst=0 for 3 cycles mid-program → next edge csb=1, pgm=0, en=0, short=1, sclk=0, busy=0; rd_data=0.
- Program, FUSE_BITS=8, PWR_CYC=4, tckhp=3, prog=8'hA5 → 8 SCLK pulses, each 3 high / 1 low. pgm is high only during the pulses for bits 0, 2, 5, 7. busy lasts 45 cycles, then a 1-cycle done.
- tckhp=0 → SCLK high 1 cycle per bit; busy lasts 3·4+1+8·2 = 29 cycles.
- Read, FUSE_BITS=8, dout driven with 8'h3C LSB first, aligned to RD_HI → rd_data=8'h3C at done. en stays 0 throughout; busy lasts 17 cycles.
- mode=2'b11 start, and a second start edge while busy → no state change and no extra done.
- With EFUSE_VERIFY_EN: prog=8'hA5 and a dout model returning 8'hA4 → verify_err=1 at done. Returning 8'hA5 → verify_err=0. Total busy lasts 62 cycles.
